conv2d_3x3_stream: RTL and testbench

- Streaming 3x3 convolution stage, directly upstream of maxpool2d.
- Accepts one signed Q8.8 pixel per cycle in raster order after an i_start pulse.
- Convolves with a 3x3 kernel plus bias, using zero "same" padding, then saturates and applies an optional ReLU.
- Emits an IMG_WIDTH x IMG_HEIGHT frame in the exact format maxpool2d consumes: o_start pulse, then contiguous one-per-cycle pixels.

---
 rtl/conv_pkg.sv | 36 +++
 rtl/conv_line_buffer.sv | 29 ++
 rtl/conv2d_3x3_stream.sv | 234 +++++++++++++++++++++++
 tb/tb_conv2d_3x3_stream.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the streaming 3x3 convolution stage.
package conv_pkg;

  function automatic int unsigned acc_width(input int unsigned dw);
    return 2 * dw + 4;
  endfunction

  localparam int unsigned PIX_W       = 16;
  localparam int unsigned ACC_WIDTH   = acc_width(PIX_W);
  localparam int unsigned NUM_TAPS    = 9;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned PIPE_STAGES = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    FLUSH  = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] TAP0      = 4'd0;
  localparam logic [ADDR_W-1:0] TAP1      = 4'd1;
  localparam logic [ADDR_W-1:0] TAP2      = 4'd2;
  localparam logic [ADDR_W-1:0] TAP3      = 4'd3;
  localparam logic [ADDR_W-1:0] TAP4      = 4'd4;
  localparam logic [ADDR_W-1:0] TAP5      = 4'd5;
  localparam logic [ADDR_W-1:0] TAP6      = 4'd6;
  localparam logic [ADDR_W-1:0] TAP7      = 4'd7;
  localparam logic [ADDR_W-1:0] TAP8      = 4'd8;
  localparam logic [ADDR_W-1:0] BIAS_ADDR = 4'd9;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32767);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

endpackage

// File: rtl/conv_line_buffer.sv
// Fixed-depth shift-register row delay line with synchronous clear.
module conv_line_buffer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] line_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else if (en) begin
      line_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign dout = line_q[DEPTH-1];

endmodule

// File: rtl/conv2d_3x3_stream.sv
// Streaming 3x3 convolution with bias, zero "same" padding, saturation and
// optional ReLU; emits frames in the start/valid/done format of maxpool2d.
module conv2d_3x3_stream
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PIX_W,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned IMG_WIDTH  = 6,
  parameter int unsigned IMG_HEIGHT = 6,
  parameter int unsigned RELU_EN    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_w_we,
  input  logic [ADDR_W-1:0]     i_w_addr,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  output logic                  o_start,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_done,
  output logic                  o_busy
);

  localparam int unsigned ACC_W       = acc_width(DATA_WIDTH);
  localparam int unsigned PROD_W      = 2 * DATA_WIDTH;
  localparam int unsigned NPIX        = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned LAST_STREAM = NPIX - 1;
  localparam int unsigned LAST_FLUSH  = NPIX + IMG_WIDTH;
  localparam int unsigned LAST_DRAIN  = NPIX + IMG_WIDTH + PIPE_STAGES;
  localparam int unsigned CNT_W       = $clog2(LAST_DRAIN + 1);
  localparam int unsigned COL_W       = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W       = $clog2(IMG_HEIGHT + 1);

  localparam logic signed [ACC_W-1:0] SAT_HI =
    ACC_W'((longint'(1) <<< (DATA_WIDTH - 1)) - longint'(1));
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  state_t state, next_state;

  logic [CNT_W-1:0] cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic signed [DATA_WIDTH-1:0] taps [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] bias;

  logic                         start_ok_c;
  logic                         shift_en_c;
  logic                         win_valid_c;
  logic [DATA_WIDTH-1:0]        pix_in_c;
  logic [DATA_WIDTH-1:0]        lb1_out, lb2_out;
  logic signed [DATA_WIDTH-1:0] live [3];
  logic signed [DATA_WIDTH-1:0] win [3][2];
  logic signed [DATA_WIDTH-1:0] opnd [NUM_TAPS];
  logic                         left_ok_c, right_ok_c, top_ok_c;

  logic signed [PROD_W-1:0]     prod [NUM_TAPS];
  logic                         p_valid;
  logic signed [ACC_W-1:0]      acc_c, acc;
  logic                         s_valid;
  logic signed [ACC_W-1:0]      shifted_c, clamp_c;
  logic [DATA_WIDTH-1:0]        res_c;

  assign start_ok_c  = (state == IDLE) && i_start;
  assign shift_en_c  = (state == STREAM) || (state == FLUSH);
  assign win_valid_c = shift_en_c && (cnt >= CNT_W'(IMG_WIDTH + 1));
  // FLUSH feeds zeros that supply the bottom padding row.
  assign pix_in_c    = (state == STREAM) ? i_data : '0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_start) next_state = STREAM;
      STREAM:  if (cnt == CNT_W'(LAST_STREAM)) next_state = FLUSH;
      FLUSH:   if (cnt == CNT_W'(LAST_FLUSH)) next_state = DRAIN;
      DRAIN:   if (cnt == CNT_W'(LAST_DRAIN)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Single frame counter spans STREAM, FLUSH and DRAIN.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (start_ok_c) begin
      cnt <= '0;
    end else if ((state == STREAM) || (state == FLUSH) || (state == DRAIN)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Row/column of the current window centre.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      col <= '0;
      row <= '0;
    end else if (start_ok_c) begin
      col <= '0;
      row <= '0;
    end else if (win_valid_c) begin
      if (col == COL_W'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < int'(NUM_TAPS); i++) taps[i] <= '0;
      bias <= '0;
    end else if ((state == IDLE) && i_w_we) begin
      if (i_w_addr <= TAP8)           taps[i_w_addr] <= i_w_data;
      else if (i_w_addr == BIAS_ADDR) bias           <= i_w_data;
    end
  end

  conv_line_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
    .clk   (i_clk),
    .rst_n (i_rst),
    .en    (shift_en_c),
    .clr   (start_ok_c),
    .din   (pix_in_c),
    .dout  (lb1_out)
  );

  conv_line_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb2 (
    .clk   (i_clk),
    .rst_n (i_rst),
    .en    (shift_en_c),
    .clr   (start_ok_c),
    .din   (lb1_out),
    .dout  (lb2_out)
  );

  // The newest window column comes straight from the delay-line taps.
  assign live[0] = lb2_out;
  assign live[1] = lb1_out;
  assign live[2] = pix_in_c;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= '0;
        win[r][1] <= '0;
      end
    end else if (start_ok_c) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= '0;
        win[r][1] <= '0;
      end
    end else if (shift_en_c) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= live[r];
      end
    end
  end

  assign left_ok_c  = (col != '0);
  assign right_ok_c = (col != COL_W'(IMG_WIDTH - 1));
  assign top_ok_c   = (row != '0);

  // Padding masks zero any tap that falls outside the frame.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      opnd[r*3]     = ((r != 0 || top_ok_c) && left_ok_c)  ? win[r][0] : '0;
      opnd[r*3 + 1] = (r != 0 || top_ok_c)                 ? win[r][1] : '0;
      opnd[r*3 + 2] = ((r != 0 || top_ok_c) && right_ok_c) ? live[r]   : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < int'(NUM_TAPS); k++) prod[k] <= '0;
      p_valid <= 1'b0;
    end else begin
      for (int k = 0; k < int'(NUM_TAPS); k++) prod[k] <= PROD_W'(opnd[k]) * PROD_W'(taps[k]);
      p_valid <= win_valid_c;
    end
  end

  always_comb begin
    acc_c = ACC_W'(bias) <<< FRAC_BITS;
    for (int k = 0; k < int'(NUM_TAPS); k++) acc_c = acc_c + ACC_W'(prod[k]);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      acc     <= '0;
      s_valid <= 1'b0;
    end else begin
      acc     <= acc_c;
      s_valid <= p_valid;
    end
  end

  always_comb begin
    shifted_c = acc >>> FRAC_BITS;
    clamp_c   = shifted_c;
    if (shifted_c > SAT_HI)      clamp_c = SAT_HI;
    else if (shifted_c < SAT_LO) clamp_c = SAT_LO;
    if ((RELU_EN != 0) && clamp_c[ACC_W-1]) clamp_c = '0;
    res_c = DATA_WIDTH'(clamp_c);
  end

  // o_start fires on the first stage-2 valid of the frame.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_start <= 1'b0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_start <= p_valid && !s_valid;
      o_data  <= s_valid ? res_c : '0;
      o_valid <= s_valid;
      o_done  <= (next_state == DONE);
      o_busy  <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_conv2d_3x3_stream.sv
// Randomized scoreboard bench for conv2d_3x3_stream; two instances (ReLU off/on)
// share stimulus and are checked against a direct arithmetic convolution model.
module tb_conv2d_3x3_stream;

  localparam int W  = 6;
  localparam int H  = 6;
  localparam int NP = W * H;

  logic        clk = 1'b0;
  logic        rst, start, we;
  logic [15:0] din, wd;
  logic [3:0]  wa;
  logic        st0, v0, dn0, b0, st1, v1, dn1, b1;
  logic [15:0] d0, d1;

  always #5 clk = ~clk;

  conv2d_3x3_stream #(.DATA_WIDTH(16), .FRAC_BITS(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .RELU_EN(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_data(din), .i_w_we(we), .i_w_addr(wa),
    .i_w_data(wd), .o_start(st0), .o_data(d0), .o_valid(v0), .o_done(dn0), .o_busy(b0));

  conv2d_3x3_stream #(.DATA_WIDTH(16), .FRAC_BITS(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .RELU_EN(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_data(din), .i_w_we(we), .i_w_addr(wa),
    .i_w_data(wd), .o_start(st1), .o_data(d1), .o_valid(v1), .o_done(dn1), .o_busy(b1));

  typedef struct {
    logic [15:0] e0;
    logic [15:0] e1;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   m_tap[9];
  int   m_bias;
  int   img[NP];
  int   st_cyc = -1, fv_cyc = -1, br_cyc = -1, nval = 0;
  bit   pv = 1'b0, pb = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int s16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  // Direct zero-padded 3x3 convolution with truncation, saturation and ReLU.
  function automatic logic [15:0] ref_pix(input int r, input int c, input bit relu);
    longint acc;
    acc = longint'(m_bias) * 256;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
          acc += longint'(img[(r + dr) * W + c + dc]) * longint'(m_tap[(dr + 1) * 3 + dc + 1]);
    acc = acc >>> 8;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return acc[15:0];
  endfunction

  // Monitor: pops the scoreboard on every valid output and records frame timing.
  always @(negedge clk) begin
    if (st0) begin
      st_cyc = cyc;
      nval   = 0;
    end
    if (v0 && !pv) fv_cyc = cyc;
    if (b0 && !pb) br_cyc = cyc;
    pv = v0;
    pb = b0;
    if (v0) begin
      nval++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %0h with empty scoreboard (cycle %0d)", d0, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("pix_relu_off", int'(d0), int'(mon_e.e0));
        chk("pix_relu_on", int'(d1), int'(mon_e.e1));
        chk("valid_relu_on", int'(v1), 1);
      end
    end else begin
      chk("idle_data_zero", int'({d0, d1}), 0);
    end
  end

  task automatic m_set(input int a, input int v);
    if (a < 9) m_tap[a] = s16(v);
    else if (a == 9) m_bias = s16(v);
  endtask

  task automatic coef_write(input int a, input int v);
    @(posedge clk); #1;
    we = 1'b1; wa = 4'(a); wd = 16'(v);
    m_set(a, v);
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic load_all(input int tv, input int bv);
    for (int a = 0; a < 9; a++) coef_write(a, tv);
    coef_write(9, bv);
  endtask

  task automatic load_identity();
    for (int a = 0; a < 9; a++) coef_write(a, (a == 4) ? 16'h0100 : 0);
    coef_write(9, 0);
  endtask

  task automatic make_ramp();
    for (int i = 0; i < NP; i++) img[i] = s16(i << 8);
    img[0] = s16(16'hFF00);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < NP; i++) img[i] = s16(v);
  endtask

  task automatic do_frame(input int inj_at, input int abort_at, input bit cw,
                          input int ca, input int cv, output int s);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    if (cw) begin
      we = 1'b1; wa = 4'(ca); wd = 16'(cv);
      m_set(ca, cv);
    end
    for (int j = 0; j < NP; j++) begin
      e.e0 = ref_pix(j / W, j % W, 1'b0);
      e.e1 = ref_pix(j / W, j % W, 1'b1);
      sbq.push_back(e);
    end
    for (int k = 0; k < NP; k++) begin
      @(posedge clk); #1;
      start = 1'b0; we = 1'b0;
      din = 16'(img[k]);
      if (k == inj_at) begin
        start = 1'b1; we = 1'b1; wa = 4'd4; wd = 16'h0200;
      end
      if (k == abort_at) begin
        rst = 1'b0;
        #1;
        chk("reset_ctrl_zero", int'({st0, v0, dn0, b0, st1, v1, dn1, b1}), 0);
        chk("reset_data_zero", int'({d0, d1}), 0);
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b1; din = '0;
        for (int a = 0; a < 9; a++) m_tap[a] = 0;
        m_bias = 0;
        return;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; we = 1'b0; din = '0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (dn0) begin
        dc = cyc;
        chk("busy_at_done", int'(b0), 1);
        break;
      end
    end
    if (dc < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no o_done expected one within 300 cycles");
    end
  endtask

  task automatic check_frame(input int s, input int dc);
    chk("o_start_cycle", st_cyc, s + W + 4);
    chk("first_valid_cycle", fv_cyc, s + W + 5);
    chk("valid_count", nval, NP);
    chk("done_cycle", dc, s + W + 5 + NP);
    chk("busy_rise_cycle", br_cyc, s + 1);
    chk("scoreboard_empty", sbq.size(), 0);
  endtask

  task automatic run_frame();
    int s, dc;
    do_frame(-1, -1, 1'b0, 0, 0, s);
    wait_done(dc);
    check_frame(s, dc);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int s, dc, st_a, ndone, bad;
    rst = 1'b0; start = 1'b0; we = 1'b0; din = '0; wa = '0; wd = '0;
    for (int a = 0; a < 9; a++) m_tap[a] = 0;
    m_bias = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("por_ctrl_zero", int'({st0, v0, dn0, b0, st1, v1, dn1, b1}), 0);
    chk("por_data_zero", int'({d0, d1}), 0);
    rst = 1'b1;

    // Identity kernel over a ramp.
    load_identity();
    make_ramp();
    run_frame();

    // Unit kernel on a flat image exercises every padding mask.
    load_all(16'h0100, 0);
    fill(16'h0100);
    run_frame();

    // Saturation, negative saturation and bias-only.
    load_all(16'h7FFF, 0);
    fill(16'h7FFF);
    run_frame();
    load_all(16'hFF00, 0);
    run_frame();
    load_all(0, 16'h0180);
    for (int i = 0; i < NP; i++) img[i] = s16($urandom());
    run_frame();

    // Reset mid-frame abandons it and clears the coefficients.
    load_identity();
    make_ramp();
    do_frame(-1, 20, 1'b0, 0, 0, s);
    ndone = 0;
    repeat (80) begin
      @(negedge clk);
      if (dn0 || dn1) ndone++;
    end
    chk("no_done_after_reset", ndone, 0);
    run_frame();
    load_identity();
    run_frame();

    // Start pulse and coefficient write during a frame are both ignored.
    do_frame(15, -1, 1'b0, 0, 0, s);
    wait_done(dc);
    check_frame(s, dc);
    run_frame();

    // Back-to-back frames; the second start carries a coefficient write.
    for (int a = 0; a < 9; a++) coef_write(a, s16($urandom_range(0, 1023)) - 512);
    coef_write(9, s16($urandom_range(0, 2047)) - 1024);
    for (int i = 0; i < NP; i++) img[i] = s16($urandom());
    do_frame(-1, -1, 1'b0, 0, 0, s);
    wait_done(dc);
    check_frame(s, dc);
    st_a = st_cyc;
    for (int i = 0; i < NP; i++) img[i] = s16($urandom_range(0, 4095)) - 2048;
    do_frame(-1, -1, 1'b1, 0, 16'h0300, s);
    wait_done(dc);
    check_frame(s, dc);
    chk("b2b_start_gap", st_cyc - st_a, 48);

    // Start coincident with o_done is dropped.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (b0 || st0) bad++;
    end
    chk("start_at_done_ignored", bad, 0);

    // Random kernels and images.
    for (int f = 0; f < 4; f++) begin
      for (int a = 0; a < 9; a++)
        coef_write(a, (f == 3) ? s16($urandom()) : s16($urandom_range(0, 1023)) - 512);
      coef_write(9, s16($urandom()));
      for (int i = 0; i < NP; i++) img[i] = s16($urandom());
      run_frame();
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
